// File: rtl/bisqrt_jk_mc.sv
// Multi-channel JK-flipflop unary square root with an optional saturating
// bipolar-to-unipolar front end and a shared windowed ones-counter per channel.
module bisqrt_jk_mc #(
    parameter int CH  = 4,
    parameter int DEP = 3,
    parameter int CW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   mode,
    input  logic [CH-1:0]          in,
    output logic [CH-1:0]          out,
    output logic [CH*(CW+1)-1:0]   cnt,
    output logic                   cnt_vld
);

    localparam logic signed [DEP:0] ACC_MIN = {2'b11, {(DEP-1){1'b0}}};
    localparam logic signed [DEP:0] P_ONE   = {{DEP{1'b0}}, 1'b1};
    localparam logic signed [DEP:0] M_ONE   = '1;

    logic [CH-1:0]          r_trace;
    logic signed [DEP-1:0]  r_acc [CH];
    logic [CW:0]            r_ones [CH];
    logic [CW-1:0]          r_wcnt;
    logic [CH*(CW+1)-1:0]   r_cnt;
    logic                   r_cnt_vld;
    logic                   r_mode_q;

    logic [CH-1:0]          w_u;
    logic [CH-1:0]          w_out;
    logic signed [DEP:0]    w_sum [CH];
    logic signed [DEP:0]    w_dec [CH];
    logic signed [DEP-1:0]  w_acc_nxt [CH];
    logic                   w_clr_all;
    logic                   w_wrap;

    // A mode change behaves exactly like clr on that edge.
    assign w_clr_all = clr | (mode != r_mode_q);
    assign w_wrap    = en & (r_wcnt == '1);

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_u[i]       = 1'b0;
            w_acc_nxt[i] = '0;
            w_sum[i]     = {r_acc[i][DEP-1], r_acc[i]} + (in[i] ? P_ONE : M_ONE);
            w_dec[i]     = w_sum[i] - P_ONE;
            if (mode) begin
                // Positive sum emits a one and pays it back; otherwise floor-saturate.
                if (!w_sum[i][DEP] && (|w_sum[i])) begin
                    w_u[i]       = 1'b1;
                    w_acc_nxt[i] = w_dec[i][DEP-1:0];
                end else if (w_sum[i] < ACC_MIN) begin
                    w_acc_nxt[i] = ACC_MIN[DEP-1:0];
                end else begin
                    w_acc_nxt[i] = w_sum[i][DEP-1:0];
                end
            end else begin
                w_u[i] = in[i];
            end
            w_out[i] = r_trace[i] | w_u[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trace   <= '0;
            r_wcnt    <= '0;
            r_cnt     <= '0;
            r_cnt_vld <= 1'b0;
            r_mode_q  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_acc[i]  <= '0;
                r_ones[i] <= '0;
            end
        end else begin
            r_mode_q <= mode;
            if (w_clr_all) begin
                r_trace   <= '0;
                r_wcnt    <= '0;
                r_cnt_vld <= 1'b0;
                for (int i = 0; i < CH; i++) begin
                    r_acc[i]  <= '0;
                    r_ones[i] <= '0;
                end
            end else if (en) begin
                // JK with K=1: a set trace always toggles back to zero.
                r_trace   <= ~r_trace & w_u;
                r_wcnt    <= r_wcnt + CW'(1);
                r_cnt_vld <= w_wrap;
                for (int i = 0; i < CH; i++) begin
                    r_acc[i] <= w_acc_nxt[i];
                    if (w_wrap) begin
                        r_cnt[i*(CW+1) +: CW+1] <= r_ones[i] + (CW+1)'(w_out[i]);
                        r_ones[i]               <= '0;
                    end else begin
                        r_ones[i] <= r_ones[i] + (CW+1)'(w_out[i]);
                    end
                end
            end else begin
                r_cnt_vld <= 1'b0;
            end
        end
    end

    assign out     = w_out;
    assign cnt     = r_cnt;
    assign cnt_vld = r_cnt_vld;

endmodule
